// File: rtl/program_loader.sv
// Byte-stream program loader: assembles big-endian words from a length-prefixed frame,
// writes them to memory from address 0, and releases the CPU once the XOR checksum matches.
module program_loader #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              cpu_reset,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] word_count
);

  typedef enum logic [2:0] {
    StLenHi,
    StLenLo,
    StData,
    StWrite,
    StChk,
    StDone,
    StError
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          len_hi_q, len_hi_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [7:0]          chk_q, chk_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [ADDR_W-1:0]   word_count_q, word_count_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                ready_int;
  logic                we_int;
  logic [15:0]         len_full;

  assign len_full = {len_hi_q, rx_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StLenHi;
      len_hi_q     <= 8'h00;
      len_q        <= '0;
      word_q       <= '0;
      chk_q        <= 8'h00;
      byte_idx_q   <= 2'd0;
      word_count_q <= '0;
      cpu_reset_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      len_hi_q     <= len_hi_d;
      len_q        <= len_d;
      word_q       <= word_d;
      chk_q        <= chk_d;
      byte_idx_q   <= byte_idx_d;
      word_count_q <= word_count_d;
      cpu_reset_q  <= cpu_reset_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    len_hi_d     = len_hi_q;
    len_d        = len_q;
    word_d       = word_q;
    chk_d        = chk_q;
    byte_idx_d   = byte_idx_q;
    word_count_d = word_count_q;
    cpu_reset_d  = cpu_reset_q;
    ready_int    = 1'b0;
    we_int       = 1'b0;

    case (state_q)
      StLenHi: begin
        ready_int = 1'b1;
        if (rx_valid) begin
          len_hi_d = rx_data;
          state_d  = StLenLo;
        end
      end
      StLenLo: begin
        ready_int = 1'b1;
        if (rx_valid) begin
          len_d        = ADDR_W'(len_full);
          chk_d        = 8'h00;
          byte_idx_d   = 2'd0;
          word_count_d = '0;
          state_d      = (len_full == 16'h0000) ? StChk : StData;
        end
      end
      StData: begin
        ready_int = 1'b1;
        if (rx_valid) begin
          word_d     = {word_q[DATA_W-9:0], rx_data};
          chk_d      = chk_q ^ rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        // Single-cycle write slot; rx_ready stays low so the next word cannot start yet.
        we_int       = 1'b1;
        word_count_d = word_count_q + ADDR_W'(1);
        state_d      = (word_count_q + ADDR_W'(1) == len_q) ? StChk : StData;
      end
      StChk: begin
        ready_int = 1'b1;
        if (rx_valid) begin
          if (rx_data == chk_q) begin
            state_d     = StDone;
            cpu_reset_d = 1'b0;
          end else begin
            state_d = StError;
          end
        end
      end
      StDone, StError: begin
        if (start) begin
          state_d     = StLenHi;
          cpu_reset_d = 1'b1;
        end
      end
      default: begin
        state_d = StLenHi;
      end
    endcase
  end

  // Gated by reset so the handshake and write strobe are quiet while reset is held.
  assign rx_ready   = ready_int & ~reset;
  assign mem_we     = we_int & ~reset;
  assign mem_addr   = word_count_q;
  assign mem_wdata  = word_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = (state_q == StDone);
  assign err        = (state_q == StError);
  assign word_count = word_count_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed scenarios plus random frames checked
// against a frame-level model (expected writes and checksum computed from the word list).
module tb_program_loader;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          start;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          cpu_reset;
  logic          done;
  logic          err;
  logic [AW-1:0] word_count;

  program_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .start      (start),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] wr_addr[$];
  logic [DW-1:0] wr_data[$];
  logic [DW-1:0] fw[$];
  int ready_in_write = 0;
  int cpu_done_bad   = 0;

  // Memory-side observer: records every write and watches the reset/done relationship.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) begin
        wr_addr.push_back(mem_addr);
        wr_data.push_back(mem_wdata);
        if (rx_ready) ready_in_write++;
      end
      if (cpu_reset !== ~done) cpu_done_bad++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1);
  end

  function automatic logic [7:0] model_chk();
    logic [7:0] c = 8'h00;
    foreach (fw[i]) c = c ^ fw[i][31:24] ^ fw[i][23:16] ^ fw[i][15:8] ^ fw[i][7:0];
    return c;
  endfunction

  task automatic clear_writes();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit acc = 1'b0;
    if (gap) begin
      rx_valid = 1'b0;
      @(posedge clk); #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    for (int g = 0; g < 20 && !acc; g++) begin
      @(negedge clk);
      acc = rx_ready;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    if (!acc) begin
      errors++;
      checks++;
      $display("FAIL send_byte_timeout: rx_ready=0 for byte %02h, required 1", b);
    end
  endtask

  // Sends fw as a frame; the 4th byte of each word must produce the write on the next cycle.
  task automatic send_frame(input bit gap, input bit use_chk, input logic [7:0] chk_in);
    logic [15:0] n = 16'(fw.size());
    logic [31:0] w;
    send_byte(n[15:8], gap);
    send_byte(n[7:0], gap);
    for (int i = 0; i < fw.size(); i++) begin
      w = fw[i];
      for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], gap);
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== AW'(i) || mem_wdata !== w) begin
        errors++;
        $display("FAIL write_latency[%0d]: we=%b addr=%0h data=%08h, required we=1 addr=%0h data=%08h",
                 i, mem_we, mem_addr, mem_wdata, i, w);
      end
    end
    send_byte(use_chk ? chk_in : model_chk(), gap);
  endtask

  task automatic rearm();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rx_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, err, word_count} !==
        {1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL reset_values: rdy=%b we=%b addr=%h wd=%h cpur=%b done=%b err=%b wc=%h, required 0 0 0 0 1 0 0 0",
               rx_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, err, word_count);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: rx_ready=%b, required 1", rx_ready);
    end
  endtask

  // Common frame-outcome comparison body, inlined per scenario via this local macro-free task
  // is avoided; each scenario compares its own results below.
  task automatic test_good_frame();
    fw = '{32'hD300_0000, 32'h1234_5678};
    clear_writes();
    send_frame(1'b0, 1'b0, 8'h00);
    checks++;
    if (wr_addr.size() != 2 || wr_addr[0] !== 16'd0 || wr_data[0] !== 32'hD300_0000 ||
        wr_addr[1] !== 16'd1 || wr_data[1] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL good_writes: %0d writes, required 2 (D3000000@0, 12345678@1)", wr_addr.size());
    end
    checks++;
    if ({done, err, cpu_reset, word_count} !== {1'b1, 1'b0, 1'b0, 16'd2}) begin
      errors++;
      $display("FAIL good_status: done=%b err=%b cpur=%b wc=%0d, required 1 0 0 2",
               done, err, cpu_reset, word_count);
    end
  endtask

  task automatic test_bad_chk();
    bit exp_good;
    rearm();
    fw = '{32'hD300_0000, 32'h1234_5678};
    exp_good = (model_chk() == 8'h00);
    clear_writes();
    send_frame(1'b0, 1'b1, 8'h00);
    checks++;
    if (wr_addr.size() != 2 || wr_data[0] !== 32'hD300_0000 || wr_data[1] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL bad_chk_writes: %0d writes, required 2", wr_addr.size());
    end
    checks++;
    if ({done, err, cpu_reset, word_count} !== {exp_good, ~exp_good, ~exp_good, 16'd2}) begin
      errors++;
      $display("FAIL bad_chk_status: done=%b err=%b cpur=%b wc=%0d, required %b %b %b 2",
               done, err, cpu_reset, word_count, exp_good, ~exp_good, ~exp_good);
    end
  endtask

  task automatic test_zero_len();
    rearm();
    fw.delete();
    clear_writes();
    send_frame(1'b0, 1'b1, 8'h00);
    checks++;
    if (wr_addr.size() != 0 || done !== 1'b1 || err !== 1'b0 || word_count !== 16'd0) begin
      errors++;
      $display("FAIL zero_len: writes=%0d done=%b err=%b wc=%0d, required 0 1 0 0",
               wr_addr.size(), done, err, word_count);
    end
  endtask

  task automatic test_throttled();
    rearm();
    fw = '{32'hD300_0000, 32'h1234_5678};
    clear_writes();
    send_frame(1'b1, 1'b0, 8'h00);
    checks++;
    if (wr_addr.size() != 2 || wr_data[0] !== 32'hD300_0000 || wr_data[1] !== 32'h1234_5678 ||
        done !== 1'b1 || cpu_reset !== 1'b0) begin
      errors++;
      $display("FAIL throttled: writes=%0d done=%b cpur=%b, required 2 1 0",
               wr_addr.size(), done, cpu_reset);
    end
    checks++;
    if (ready_in_write != 0) begin
      errors++;
      $display("FAIL ready_in_write: %0d cycles with rx_ready during write, required 0", ready_in_write);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] part[6];
    part = '{8'h00, 8'h02, 8'hD3, 8'h00, 8'h00, 8'h00};
    rearm();
    clear_writes();
    foreach (part[i]) send_byte(part[i], 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (wr_addr.size() != 1 || wr_data[0] !== 32'hD300_0000 || word_count !== 16'd0 ||
        cpu_reset !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: writes=%0d wc=%0d cpur=%b done=%b, required 1 0 1 0",
               wr_addr.size(), word_count, cpu_reset, done);
    end
    reset = 1'b0;
    fw = '{32'hD300_0000, 32'h1234_5678};
    clear_writes();
    send_frame(1'b0, 1'b0, 8'h00);
    checks++;
    if (wr_addr.size() != 2 || wr_addr[0] !== 16'd0 || wr_addr[1] !== 16'd1 ||
        wr_data[1] !== 32'h1234_5678 || done !== 1'b1) begin
      errors++;
      $display("FAIL resend_after_reset: writes=%0d done=%b, required 2 1", wr_addr.size(), done);
    end
  endtask

  task automatic test_done_rearm();
    int seen_ready = 0;
    clear_writes();
    rx_data = 8'hAA; rx_valid = 1'b1; start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rx_ready) seen_ready++;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    checks++;
    if (seen_ready != 0 || wr_addr.size() != 0 || done !== 1'b1) begin
      errors++;
      $display("FAIL done_ignores_bytes: ready_cycles=%0d writes=%0d done=%b, required 0 0 1",
               seen_ready, wr_addr.size(), done);
    end
    rearm();
    checks++;
    if (done !== 1'b0 || cpu_reset !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL rearm: done=%b cpur=%b err=%b, required 0 1 0", done, cpu_reset, err);
    end
    fw = '{$urandom()};
    send_frame(1'b0, 1'b0, 8'h00);
    checks++;
    if (wr_addr.size() != 1 || wr_addr[0] !== 16'd0 || wr_data[0] !== fw[0] ||
        word_count !== 16'd1 || done !== 1'b1) begin
      errors++;
      $display("FAIL rearm_frame: writes=%0d wc=%0d done=%b, required 1 1 1",
               wr_addr.size(), word_count, done);
    end
  endtask

  task automatic test_random_frames();
    for (int it = 0; it < 8; it++) begin
      int  n    = $urandom_range(1, 6);
      bit  good = 1'($urandom_range(0, 1));
      bit  gap  = 1'($urandom_range(0, 1));
      logic [7:0] c;
      bit  ok = 1'b1;
      rearm();
      fw.delete();
      for (int i = 0; i < n; i++) fw.push_back($urandom());
      c = good ? model_chk() : model_chk() ^ 8'($urandom_range(1, 255));
      clear_writes();
      send_frame(gap, 1'b1, c);
      if (wr_addr.size() != n) ok = 1'b0;
      else foreach (fw[i]) if (wr_addr[i] !== AW'(i) || wr_data[i] !== fw[i]) ok = 1'b0;
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL random_writes[%0d]: %0d writes, required %0d matching model", it,
                 wr_addr.size(), n);
      end
      checks++;
      if ({done, err, cpu_reset, word_count} !== {good, ~good, ~good, AW'(n)}) begin
        errors++;
        $display("FAIL random_status[%0d]: done=%b err=%b cpur=%b wc=%0d, required %b %b %b %0d",
                 it, done, err, cpu_reset, word_count, good, ~good, ~good, n);
      end
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (cpu_done_bad != 0 || ready_in_write != 0) begin
      errors++;
      $display("FAIL invariants: cpu_reset/done disagreements=%0d ready_in_write=%0d, required 0 0",
               cpu_done_bad, ready_in_write);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_zero_len();
    test_throttled();
    test_mid_reset();
    test_done_rearm();
    test_random_frames();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
